// File: rtl/twiddle_pkg.sv
// Shared types and constants for the NTT twiddle-factor table generator.
package twiddle_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_e;

    localparam int unsigned Q_DEFAULT       = 65537;
    localparam int unsigned PSI_DEFAULT     = 2;
    localparam int unsigned PSI_INV_DEFAULT = 32769;

    // Reverse the low n bits of a; bits above n come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] a, input int unsigned n);
        logic [31:0] src;
        logic [31:0] r;
        src = a;
        r   = '0;
        for (int unsigned i = 0; i < n; i++) begin
            r   = {r[30:0], src[0]};
            src = src >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/twiddle_gen_mod_mul.sv
// Combinational modular multiply: p = (a * b) mod Q using a full 2*QW-bit product.
module mod_mul
    import twiddle_pkg::*;
#(
    parameter int unsigned QW = 17,
    parameter int unsigned Q  = Q_DEFAULT
) (
    input  logic [QW-1:0] a_i,
    input  logic [QW-1:0] b_i,
    output logic [QW-1:0] p_o
);

    localparam logic [2*QW-1:0] QL = (2*QW)'(Q);

    logic [2*QW-1:0] prod;
    logic [2*QW-1:0] rem;

    always_comb begin
        prod = (2*QW)'(a_i) * (2*QW)'(b_i);
        rem  = prod % QL;
        p_o  = rem[QW-1:0];
    end

endmodule

// File: rtl/twiddle_gen.sv
// Twiddle table generator: fills table[a] = R^bitrev(a) mod Q, R = PSI or PSI_INV.
// Optional macro TWIDDLE_AUTOLOAD_EN starts a forward fill on the first cycle out of reset.
module twiddle_gen
    import twiddle_pkg::*;
#(
    parameter int unsigned LOGN    = 4,
    parameter int unsigned QW      = 17,
    parameter int unsigned Q       = Q_DEFAULT,
    parameter int unsigned PSI     = PSI_DEFAULT,
    parameter int unsigned PSI_INV = PSI_INV_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            inv,
    output logic            busy,
    output logic            done,
    output logic            table_valid,
    output logic            table_inv,
    input  logic            rd_en,
    input  logic [LOGN-1:0] rd_addr,
    output logic            rd_valid,
    output logic [QW-1:0]   rd_data
);

    localparam int unsigned   N     = 1 << LOGN;
    localparam logic [QW-1:0] R_FWD = QW'(PSI);
    localparam logic [QW-1:0] R_INV = QW'(PSI_INV);

    state_e          state_q;
    logic            mode_q;
    logic [LOGN-1:0] k_q;
    logic [QW-1:0]   w_q;
    logic [QW-1:0]   w_d;
    logic [QW-1:0]   root;
    logic            busy_q;
    logic            done_q;
    logic            valid_q;
    logic            tinv_q;
    logic            rd_valid_q;
    logic [QW-1:0]   rd_data_q;
    logic [LOGN-1:0] wr_addr;
    logic            start_eff;
    logic            inv_eff;

    logic [QW-1:0]   mem [N];

`ifdef TWIDDLE_AUTOLOAD_EN
    logic autoload_q;

    always_ff @(posedge clk) begin
        autoload_q <= ~rst_n;
    end

    assign start_eff = start | autoload_q;
    assign inv_eff   = inv & ~autoload_q;
`else
    assign start_eff = start;
    assign inv_eff   = inv;
`endif

    assign root    = mode_q ? R_INV : R_FWD;
    assign wr_addr = LOGN'(bitrev(32'(k_q), LOGN));

    mod_mul #(
        .QW (QW),
        .Q  (Q)
    ) u_mod_mul (
        .a_i (w_q),
        .b_i (root),
        .p_o (w_d)
    );

    always_ff @(posedge clk) begin
        if (state_q == FILL) begin
            mem[wr_addr] <= w_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            k_q        <= '0;
            w_q        <= QW'(1);
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            tinv_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_eff) begin
                        mode_q  <= inv_eff;
                        k_q     <= '0;
                        w_q     <= QW'(1);
                        valid_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    w_q <= w_d;
                    k_q <= k_q + LOGN'(1);
                    if (k_q == LOGN'(N - 1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        valid_q <= 1'b1;
                        tinv_q  <= mode_q;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            // Rejected reads still answer, with valid low and data forced to zero.
            if (rd_en) begin
                if (valid_q && !busy_q) begin
                    rd_valid_q <= 1'b1;
                    rd_data_q  <= mem[rd_addr];
                end else begin
                    rd_valid_q <= 1'b0;
                    rd_data_q  <= '0;
                end
            end else begin
                rd_valid_q <= 1'b0;
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign table_valid = valid_q;
    assign table_inv   = tinv_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;

endmodule
